// File: rtl/wb_pkg.sv
// wb_pkg: shared state type and default parameters for the Wishbone request master
package wb_pkg;
   localparam int AW_DEF  = 24;
   localparam int LW_DEF  = 8;
   localparam int TMO_DEF = 16;
   typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} state_e;
endpackage

// File: rtl/wb_tmo_cnt.sv
// wb_tmo_cnt: per-beat ack timeout counter, expires on the TMO-th enabled cycle
module wb_tmo_cnt #(
   parameter int TMO = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic exp_o
);
   localparam int CW = $clog2(TMO + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
      exp_o = en_i && (cnt_q == CW'(TMO - 1));
   end
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/wb_req_master.sv
// wb_req_master: issues a burst of single Wishbone beats with per-beat timeout and abort
module wb_req_master
   import wb_pkg::*;
#(
   parameter int AW  = AW_DEF,
   parameter int LW  = LW_DEF,
   parameter int TMO = TMO_DEF
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic          we_i,
   input  logic [AW-1:0] adr_i,
   input  logic [LW-1:0] len_i,
   input  logic          abort_i,
   output logic          cyc_o,
   output logic          stb_o,
   output logic          we_o,
   output logic [AW-1:0] adr_o,
   input  logic          ack_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o,
   output logic [LW-1:0] beats_o
);
   state_e        state_q, state_d;
   logic [AW-1:0] adr_q, adr_d;
   logic [LW-1:0] len_q, len_d, beats_q, beats_d, beats_inc;
   logic          we_q, we_d, cyc_q, busy_q, done_q, err_q;
   logic          in_bus, tmo_exp;
   assign in_bus    = (state_q == BUS);
   assign beats_inc = beats_q + 1'b1;
   wb_tmo_cnt #(.TMO(TMO)) u_tmo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (!in_bus || ack_i),
      .en_i  (in_bus && !ack_i),
      .exp_o (tmo_exp)
   );
   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      we_d    = we_q;
      len_d   = len_q;
      beats_d = beats_q;
      case (state_q)
         IDLE: if (start_i) begin
            beats_d = '0;
            state_d = (len_i != '0) ? BUS : DONE;
            if (len_i != '0) begin
               adr_d = adr_i;
               we_d  = we_i;
               len_d = len_i;
            end
         end
         BUS: begin
            if (ack_i) begin
               beats_d = beats_inc;
               adr_d   = adr_q + 1'b1;
            end
            // abort outranks completion, which outranks timeout
            state_d = abort_i                       ? ERR  :
                      (ack_i && beats_inc == len_q) ? DONE :
                      tmo_exp                       ? ERR  : BUS;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         state_q <= IDLE;
         adr_q   <= '0;
         we_q    <= 1'b0;
         len_q   <= '0;
         beats_q <= '0;
         cyc_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         we_q    <= we_d;
         len_q   <= len_d;
         beats_q <= beats_d;
         cyc_q   <= (state_d == BUS);
         busy_q  <= (state_d != IDLE);
         done_q  <= (state_d == DONE);
         err_q   <= (state_d == ERR);
      end
   assign cyc_o   = cyc_q;
   assign stb_o   = cyc_q;
   assign we_o    = we_q;
   assign adr_o   = adr_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign err_o   = err_q;
   assign beats_o = beats_q;
endmodule
